// File: rtl/msdap_pkg.sv
// Shared constants and types for the MSDAP serial front end.
package msdap_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PUBLISH = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_shift_word.sv
// One channel's MSB-first serial-to-parallel shift register.
// load_clear starts a fresh word; a shift on the same cycle makes that bit
// the first (most significant) bit of the new word.
module serial_shift_word #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load_clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word
);

    // Shift new bits into the LSB; restart from zero on load_clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            word <= '0;
        end else if (load_clear) begin
            word <= shift_en ? {{(WORD_W-1){1'b0}}, bit_in} : '0;
        end else if (shift_en) begin
            word <= {word[WORD_W-2:0], bit_in};
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Captures one stereo sample per frame from the serial inputs and publishes
// the parallel words with a one-cycle strobe and a wrapping write address.
module serial_frame_receiver #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              frame_pulse,
    input  logic              bit_strobe,
    input  logic              InputL,
    input  logic              InputR,
    output logic [WORD_W-1:0] dataL,
    output logic [WORD_W-1:0] dataR,
    output logic              data_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_error
);

    import msdap_pkg::*;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    rx_state_t         state_reg;
    logic [CNT_W-1:0]  count_reg;
    // A frame pulse seen on the completing strobe starts the next frame
    // from the PUBLISH cycle, so it has to be remembered for one cycle.
    logic              pending_reg;

    logic              completing;
    logic              restart;
    logic              shift_en;
    logic [1:0]        serial_in;
    logic [WORD_W-1:0] word [2];

    assign serial_in = {InputR, InputL};

    // Decode when the shift registers restart and when they take a bit.
    always_comb begin
        completing = 1'b0;
        restart    = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                restart = frame_pulse;
            end
            SHIFT: begin
                completing = bit_strobe && (count_reg == LAST_BIT);
                restart    = frame_pulse && !completing;
            end
            PUBLISH: begin
                restart = frame_pulse || pending_reg;
            end
            default: begin
                restart = 1'b0;
            end
        endcase
        shift_en = bit_strobe && (restart || (state_reg == SHIFT));
    end

    // Index 0 is the left channel, index 1 the right channel.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            serial_shift_word #(
                .WORD_W(WORD_W)
            ) u_shift (
                .clk        (clk),
                .clear      (clear),
                .load_clear (restart),
                .shift_en   (shift_en),
                .bit_in     (serial_in[gi]),
                .word       (word[gi])
            );
        end
    endgenerate

    // Frame FSM: bit counting, publish strobe, address and sticky error.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            pending_reg <= 1'b0;
            dataL       <= '0;
            dataR       <= '0;
            data_valid  <= 1'b0;
            wr_addr     <= '0;
            frame_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_pulse) begin
                        state_reg <= SHIFT;
                        count_reg <= CNT_W'(bit_strobe);
                    end
                end
                SHIFT: begin
                    if (completing) begin
                        // Publish includes the bit arriving this cycle.
                        dataL       <= {word[0][WORD_W-2:0], InputL};
                        dataR       <= {word[1][WORD_W-2:0], InputR};
                        data_valid  <= 1'b1;
                        count_reg   <= count_reg + 1'b1;
                        pending_reg <= frame_pulse;
                        state_reg   <= PUBLISH;
                    end else if (frame_pulse) begin
                        frame_error <= 1'b1;
                        count_reg   <= CNT_W'(bit_strobe);
                    end else if (bit_strobe) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                PUBLISH: begin
                    wr_addr     <= wr_addr + 1'b1;
                    pending_reg <= 1'b0;
                    if (frame_pulse || pending_reg) begin
                        state_reg <= SHIFT;
                        count_reg <= CNT_W'(bit_strobe);
                    end else begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

endmodule
